// File: rtl/decryptor_pkg.sv
// Shared encodings for the decryptor dispatch controller: engine select
// codes, engine count, default start-decryption token and FSM states.
package decryptor_pkg;

    localparam int NUM_ENGINES = 3;

    typedef enum logic [1:0] {
        SEL_CAESAR  = 2'd0,
        SEL_SCYTALE = 2'd1,
        SEL_ZIGZAG  = 2'd2,
        SEL_INVALID = 2'd3
    } sel_e;

    localparam logic [7:0] DEFAULT_START_TOKEN = 8'hFA;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DROP,
        WAIT_BUSY,
        DRAIN
    } state_e;

endpackage

// File: rtl/dispatch_lane_mux.sv
// Registered engine-to-output mux: while enabled, captures the plaintext
// and valid of the engine selected by sel_i; otherwise outputs zero.
module dispatch_lane_mux
    import decryptor_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_i,
    input  logic [1:0]                     sel_i,
    input  logic [NUM_ENGINES*D_WIDTH-1:0] eng_data_i,
    input  logic [NUM_ENGINES-1:0]         eng_valid_i,
    output logic [D_WIDTH-1:0]             data_o,
    output logic                           valid_o
);

    logic [D_WIDTH-1:0] data_d, data_q;
    logic               valid_d, valid_q;

    // Select the active engine's lane; zero when disabled or out of range.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        data_d  = '0;
        valid_d = 1'b0;
        if (en_i) begin
            for (int k = 0; k < NUM_ENGINES; k++) begin
                if (sel_i == 2'(k)) begin
                    data_d  = eng_data_i[k*D_WIDTH +: D_WIDTH];
                    valid_d = eng_valid_i[k];
                end
            end
        end
    end

    // One-cycle output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together at the edge.
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/decryptor_dispatch_ctrl.sv
// Dispatch controller: routes one message at a time to the caesar, scytale
// or zigzag engine, waits for the engine to run, then returns its plaintext.
// Optional feature macro: DISPATCH_ERR_CNT_EN adds a saturating err_cnt_o.
module decryptor_dispatch_ctrl
    import decryptor_pkg::*;
#(
    parameter int                 D_WIDTH                = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEFAULT_START_TOKEN),
    parameter int                 BUSY_TIMEOUT           = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [D_WIDTH-1:0]             data_i,
    input  logic                           valid_i,
    input  logic [1:0]                     sel_i,
    output logic                           ready_o,
    output logic [NUM_ENGINES*D_WIDTH-1:0] eng_data_o,
    input  logic [NUM_ENGINES-1:0]         eng_busy_i,
    input  logic [NUM_ENGINES*D_WIDTH-1:0] eng_data_i,
    input  logic [NUM_ENGINES-1:0]         eng_valid_i,
    output logic [D_WIDTH-1:0]             data_o,
    output logic                           valid_o,
    output logic                           busy_o,
`ifdef DISPATCH_ERR_CNT_EN
    output logic [7:0]                     err_cnt_o,
`endif
    output logic                           err_o
);

    localparam int CNT_W   = $clog2(MAX_NOF_CHARS + 1);
    localparam int TMO_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam int LANES_W = NUM_ENGINES * D_WIDTH;

    state_e               state_q;
    logic [1:0]           sel_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [TMO_W-1:0]     tmo_q;
    logic                 ovf_q;
    logic                 err_q;
    logic [LANES_W-1:0]   eng_data_q;

    logic accept;
    logic is_token;
    logic is_char;
    logic busy_sel;

    // Places a character on one lane with every other lane zero.
    function automatic logic [LANES_W-1:0] place_on_lane(input logic [1:0] lane,
                                                         input logic [D_WIDTH-1:0] ch);
        place_on_lane = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (lane == 2'(k)) place_on_lane[k*D_WIDTH +: D_WIDTH] = ch;
        end
    endfunction

    assign ready_o  = (state_q == IDLE) || (state_q == COLLECT) || (state_q == DROP);
    assign accept   = valid_i && ready_o;
    assign is_token = (data_i == START_DECRYPTION_TOKEN);
    assign is_char  = (data_i != '0) && !is_token;

    // Busy flag of the latched engine only.
    always_comb begin
        busy_sel = 1'b0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (sel_q == 2'(k)) busy_sel = eng_busy_i[k];
        end
    end

    // Message FSM with its counters, error pulse and registered lane drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            eng_data_q <= '0;
        end else begin
            eng_data_q <= '0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && is_char) begin
                        if (sel_i == SEL_INVALID) begin
                            err_q   <= 1'b1;
                            state_q <= DROP;
                        end else begin
                            sel_q      <= sel_i;
                            cnt_q      <= CNT_W'(1);
                            eng_data_q <= place_on_lane(sel_i, data_i);
                            state_q    <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept && is_token) begin
                        eng_data_q <= place_on_lane(sel_q, data_i);
                        tmo_q      <= '0;
                        ovf_q      <= 1'b0;
                        state_q    <= WAIT_BUSY;
                    end else if (accept && is_char) begin
                        if (cnt_q < CNT_W'(MAX_NOF_CHARS)) begin
                            eng_data_q <= place_on_lane(sel_q, data_i);
                            cnt_q      <= cnt_q + CNT_W'(1);
                        end else if (!ovf_q) begin
                            // Overflow is reported once per message.
                            err_q <= 1'b1;
                            ovf_q <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (accept && is_token) state_q <= IDLE;
                end
                WAIT_BUSY: begin
                    // Busy takes priority over an expiring timeout.
                    if (busy_sel) begin
                        state_q <= DRAIN;
                    end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
                        tmo_q   <= TMO_W'(BUSY_TIMEOUT);
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                DRAIN: begin
                    if (!busy_sel) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dispatch_lane_mux #(
        .D_WIDTH (D_WIDTH)
    ) u_lane_mux (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == DRAIN),
        .sel_i       (sel_q),
        .eng_data_i  (eng_data_i),
        .eng_valid_i (eng_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o)
    );

    assign eng_data_o = eng_data_q;
    assign busy_o     = (state_q != IDLE);
    assign err_o      = err_q;

`ifdef DISPATCH_ERR_CNT_EN
    logic [7:0] err_cnt_d, err_cnt_q;

    // Saturating count of error pulses.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= 8'd0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_decryptor_dispatch_ctrl.sv
// Directed testbench for decryptor_dispatch_ctrl: zigzag path with select
// latch, overflow, busy timeout, invalid select and async reset in DRAIN.
module tb_decryptor_dispatch_ctrl;

    localparam logic [7:0] TOK = 8'hFA;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic [1:0]  sel_i = '0;
    logic        ready_o;
    logic [23:0] eng_data_o;
    logic [2:0]  eng_busy_i = '0;
    logic [23:0] eng_data_i = '0;
    logic [2:0]  eng_valid_i = '0;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        busy_o;
    logic        err_o;
`ifdef DISPATCH_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int lane_cnt [3] = '{0, 0, 0};
    int err_seen = 0;
    int base_lane [3];
    int base_err;

    logic [7:0] zz_in  [5] = '{8'h41, 8'h43, 8'h45, 8'h42, 8'h44}; // "ACEBD"
    logic [7:0] zz_out [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45}; // "ABCDE"

    decryptor_dispatch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .sel_i       (sel_i),
        .ready_o     (ready_o),
        .eng_data_o  (eng_data_o),
        .eng_busy_i  (eng_busy_i),
        .eng_data_i  (eng_data_i),
        .eng_valid_i (eng_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
`ifdef DISPATCH_ERR_CNT_EN
        .err_cnt_o   (err_cnt_o),
`endif
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Lane and error-pulse activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++)
                if (eng_data_o[k*8 +: 8] != 8'h00) lane_cnt[k]++;
            if (err_o) err_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch, input logic [1:0] sel);
        valid_i = 1'b1;
        data_i  = ch;
        sel_i   = sel;
        tick();
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic snapshot();
        for (int k = 0; k < 3; k++) base_lane[k] = lane_cnt[k];
        base_err = err_seen;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_err", err_o, 0);
        check("rst_lanes", eng_data_o, 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Token in IDLE is ignored
        send(TOK, 2'd0);
        check("empty_busy", busy_o, 0);
        check("empty_err", err_o, 0);
        check("empty_lanes", eng_data_o, 0);

        // Zigzag path, select changes 2->0 mid-message
        for (int i = 0; i < 5; i++) begin
            send(zz_in[i], (i < 2) ? 2'd2 : 2'd0);
            check("zz_lane", eng_data_o, {zz_in[i], 16'h0000});
            check("zz_ready", ready_o, 1);
        end
        send(TOK, 2'd0);
        check("zz_tok_lane", eng_data_o, {TOK, 16'h0000});
        check("zz_wait_ready", ready_o, 0);
        check("zz_wait_busy", busy_o, 1);
        tick();
        check("zz_lane_zero", eng_data_o, 0);
        eng_busy_i = 3'b100;
        tick();
        for (int i = 0; i < 5; i++) begin
            eng_data_i  = {zz_out[i], 8'h00, 8'h55};
            eng_valid_i = 3'b101;
            tick();
            check("zz_data_o", data_o, zz_out[i]);
            check("zz_valid_o", valid_o, 1);
            check("zz_drain_ready", ready_o, 0);
        end
        eng_busy_i  = 3'b000;
        eng_valid_i = 3'b000;
        eng_data_i  = '0;
        tick();
        check("zz_end_valid", valid_o, 0);
        check("zz_end_data", data_o, 0);
        check("zz_end_ready", ready_o, 1);
        check("zz_end_busy", busy_o, 0);

        // Overflow on scytale, then busy timeout
        tick();
        snapshot();
        for (int i = 0; i < 52; i++) begin
            send(8'(i + 1), 2'd1);
            if (i == 49) check("ovf_ch50_lane", eng_data_o, {8'h00, 8'(i + 1), 8'h00});
            if (i == 50) begin
                check("ovf_ch51_err", err_o, 1);
                check("ovf_ch51_lane", eng_data_o, 0);
            end
            if (i == 51) check("ovf_ch52_err", err_o, 0);
        end
        send(TOK, 2'd1);
        check("ovf_tok_lane", eng_data_o, {8'h00, TOK, 8'h00});
        repeat (3) tick();
        check("tmo_err_early", err_o, 0);
        check("tmo_busy_early", busy_o, 1);
        tick();
        check("tmo_err", err_o, 1);
        check("tmo_busy", busy_o, 0);
        check("tmo_ready", ready_o, 1);
        tick();
        check("tmo_err_pulse", err_o, 0);
        check("ovf_fwd_cnt", 32'(lane_cnt[1] - base_lane[1]), 51);
        check("ovf_other_lanes", 32'(lane_cnt[0] - base_lane[0] + lane_cnt[2] - base_lane[2]), 0);
        check("ovf_err_cnt", 32'(err_seen - base_err), 2);

        // Invalid select
        snapshot();
        send(8'h58, 2'd3);
        check("inv_err", err_o, 1);
        check("inv_busy", busy_o, 1);
        send(8'h59, 2'd3);
        check("inv_err_once", err_o, 0);
        send(8'h5A, 2'd3);
        send(TOK, 2'd3);
        check("inv_idle_busy", busy_o, 0);
        check("inv_idle_ready", ready_o, 1);
        tick();
        check("inv_lanes", 32'(lane_cnt[0] + lane_cnt[1] + lane_cnt[2]
                               - base_lane[0] - base_lane[1] - base_lane[2]), 0);
        check("inv_err_cnt", 32'(err_seen - base_err), 1);

        // Async reset during DRAIN
        send(8'h51, 2'd0);
        send(TOK, 2'd0);
        eng_busy_i = 3'b001;
        tick();
        eng_data_i  = {16'h0000, 8'h71};
        eng_valid_i = 3'b001;
        tick();
        check("drn_data_o", data_o, 8'h71);
        check("drn_valid_o", valid_o, 1);
        check("drn_busy", busy_o, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_data", data_o, 0);
        check("arst_ready", ready_o, 1);
        check("arst_busy", busy_o, 0);
        check("arst_lanes", eng_data_o, 0);
`ifdef DISPATCH_ERR_CNT_EN
        check("arst_err_cnt", err_cnt_o, 0);
`endif
        eng_busy_i  = '0;
        eng_valid_i = '0;
        eng_data_i  = '0;
        @(negedge clk) rst = 1'b0;
        tick();
        check("post_rst_ready", ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
